// File: rtl/spatz_vlsu_mem_sequencer.sv
// Multi-port memory request sequencer for the Spatz VLSU: spreads one vector memory
// command across NrMemPorts ports and completes once every issued request is acknowledged.
module spatz_vlsu_mem_sequencer #(
  parameter int unsigned NrMemPorts    = 2,
  parameter int unsigned NrOutstanding = 8,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned VlWidth       = 16,
  parameter int unsigned ElenB         = 4,
  localparam int unsigned IdWidth      = $clog2(NrOutstanding)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [AddrWidth-1:0]            cmd_base_i,
  input  logic [AddrWidth-1:0]            cmd_stride_i,
  input  logic [VlWidth-1:0]              cmd_vl_i,
  input  logic [1:0]                      cmd_ew_i,
  input  logic                            cmd_strided_i,
  input  logic                            cmd_store_i,
  output logic [NrMemPorts-1:0]           req_valid_o,
  input  logic [NrMemPorts-1:0]           req_ready_i,
  output logic [NrMemPorts*AddrWidth-1:0] req_addr_o,
  output logic [NrMemPorts*ElenB-1:0]     req_strb_o,
  output logic [NrMemPorts-1:0]           req_we_o,
  output logic [NrMemPorts*IdWidth-1:0]   req_id_o,
  output logic [NrMemPorts*VlWidth-1:0]   req_elem_o,
  input  logic [NrMemPorts-1:0]           rsp_valid_i,
  output logic                            busy_o,
  output logic                            done_o
);
  localparam int unsigned LogE     = $clog2(ElenB);
  localparam int unsigned CrWidth  = IdWidth + 1;
  localparam int unsigned TotWidth = VlWidth + 2;

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready_o high
  // ISSUE | ports issuing their request quotas
  // DRAIN | all requests issued, waiting for outstanding responses
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q   [NrMemPorts];
  logic [VlWidth-1:0]   rem_q    [NrMemPorts];
  logic [VlWidth-1:0]   idx_q    [NrMemPorts];
  logic [IdWidth-1:0]   id_q     [NrMemPorts];
  logic [CrWidth-1:0]   credit_q [NrMemPorts];
  logic [VlWidth-1:0]   quota_in [NrMemPorts];

  logic                 word_q, store_q;
  logic [1:0]           ew_q;
  logic [AddrWidth-1:0] step_q;
  logic [VlWidth-1:0]   last_q;
  logic [ElenB-1:0]     tail_strb_q;

  logic                 accept, word_in, all_issued, all_drained;
  logic [1:0]           ew_in;
  logic [TotWidth-1:0]  bytes_in;
  logic [VlWidth-1:0]   w_in;
  logic [AddrWidth-1:0] step_in;
  logic [LogE-1:0]      tail_in;
  logic [ElenB-1:0]     tail_strb_in, elem_mask;
  logic [NrMemPorts-1:0] valid, hs;

  assign accept       = cmd_valid_i && cmd_ready_o;
  assign ew_in        = (cmd_ew_i == 2'd3) ? 2'd2 : cmd_ew_i;
  assign bytes_in     = TotWidth'(cmd_vl_i) << ew_in;
  assign word_in      = !cmd_strided_i && (cmd_base_i[LogE-1:0] == '0);
  assign w_in         = word_in ? VlWidth'((bytes_in + TotWidth'(ElenB - 1)) >> LogE) : cmd_vl_i;
  assign tail_in      = bytes_in[LogE-1:0];
  assign tail_strb_in = (tail_in == '0) ? '1 : ~({ElenB{1'b1}} << tail_in);
  // misaligned unit-stride falls back to element mode with an element-sized step
  assign step_in      = word_in ? AddrWidth'(ElenB) :
                        (cmd_strided_i ? cmd_stride_i : (AddrWidth'(1) << ew_in));
  assign elem_mask    = ElenB'((32'd1 << (32'd1 << ew_q)) - 32'd1);

  always_comb begin
    all_issued  = 1'b1;
    all_drained = 1'b1;
    valid       = '0;
    for (int i = 0; i < NrMemPorts; i++) begin
      quota_in[i] = VlWidth'(w_in / VlWidth'(NrMemPorts)) +
                    ((VlWidth'(i) < (w_in % VlWidth'(NrMemPorts))) ? VlWidth'(1) : VlWidth'(0));
      valid[i]    = (state_q == ISSUE) && (rem_q[i] != '0) &&
                    (credit_q[i] < CrWidth'(NrOutstanding));
      if (rem_q[i] != '0)    all_issued  = 1'b0;
      if (credit_q[i] != '0) all_drained = 1'b0;
    end
  end

  assign hs = valid & req_ready_i;

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = (cmd_vl_i == '0) ? DRAIN : ISSUE;
      end
      ISSUE: if (all_issued) state_d = DRAIN;
      DRAIN: begin
        if (all_drained) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      word_q      <= 1'b0;
      store_q     <= 1'b0;
      ew_q        <= '0;
      step_q      <= '0;
      last_q      <= '0;
      tail_strb_q <= '0;
      for (int i = 0; i < NrMemPorts; i++) begin
        addr_q[i]   <= '0;
        rem_q[i]    <= '0;
        idx_q[i]    <= '0;
        id_q[i]     <= '0;
        credit_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q      <= word_in;
        store_q     <= cmd_store_i;
        ew_q        <= ew_in;
        step_q      <= step_in;
        last_q      <= w_in - VlWidth'(1);
        tail_strb_q <= tail_strb_in;
      end
      for (int i = 0; i < NrMemPorts; i++) begin
        if (accept) begin
          addr_q[i] <= cmd_base_i + AddrWidth'(i) * step_in;
          rem_q[i]  <= quota_in[i];
          idx_q[i]  <= VlWidth'(i);
          id_q[i]   <= '0;
        end else if (hs[i]) begin
          addr_q[i] <= addr_q[i] + AddrWidth'(NrMemPorts) * step_q;
          rem_q[i]  <= rem_q[i] - VlWidth'(1);
          idx_q[i]  <= idx_q[i] + VlWidth'(NrMemPorts);
          id_q[i]   <= id_q[i] + IdWidth'(1);
        end
        // a stray response at zero credit is dropped rather than wrapping
        if (hs[i] && !rsp_valid_i[i])
          credit_q[i] <= credit_q[i] + CrWidth'(1);
        else if (!hs[i] && rsp_valid_i[i] && credit_q[i] != '0)
          credit_q[i] <= credit_q[i] - CrWidth'(1);
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign req_valid_o = valid;

  always_comb begin
    req_addr_o = '0;
    req_strb_o = '0;
    req_we_o   = '0;
    req_id_o   = '0;
    req_elem_o = '0;
    for (int i = 0; i < NrMemPorts; i++) begin
      req_addr_o[i*AddrWidth +: AddrWidth] = {addr_q[i][AddrWidth-1:LogE], {LogE{1'b0}}};
      req_we_o[i]                          = store_q;
      req_id_o[i*IdWidth +: IdWidth]       = id_q[i];
      if (busy_o) begin
        if (word_q)
          req_strb_o[i*ElenB +: ElenB] = (idx_q[i] == last_q) ? tail_strb_q : '1;
        else
          req_strb_o[i*ElenB +: ElenB] = ElenB'({{ElenB{1'b0}}, elem_mask} << addr_q[i][LogE-1:0]);
      end
      req_elem_o[i*VlWidth +: VlWidth] = word_q ?
          VlWidth'((32'(idx_q[i]) * ElenB) >> ew_q) : idx_q[i];
    end
  end

endmodule

// File: tb/tb_spatz_vlsu_mem_sequencer.sv
// Directed self-checking bench for spatz_vlsu_mem_sequencer with default parameters
// (2 ports, 8 outstanding, 32-bit addresses, 4-byte words).
module tb_spatz_vlsu_mem_sequencer;
  localparam int P  = 2;
  localparam int AW = 32;
  localparam int VW = 16;
  localparam int EB = 4;
  localparam int IW = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            cmd_valid_i, cmd_ready_o;
  logic [AW-1:0]   cmd_base_i, cmd_stride_i;
  logic [VW-1:0]   cmd_vl_i;
  logic [1:0]      cmd_ew_i;
  logic            cmd_strided_i, cmd_store_i;
  logic [P-1:0]    req_valid_o, req_ready_i, req_we_o, rsp_valid_i;
  logic [P*AW-1:0] req_addr_o;
  logic [P*EB-1:0] req_strb_o;
  logic [P*IW-1:0] req_id_o;
  logic [P*VW-1:0] req_elem_o;
  logic            busy_o, done_o;

  always #5 clk_i = ~clk_i;

  spatz_vlsu_mem_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_base_i(cmd_base_i), .cmd_stride_i(cmd_stride_i), .cmd_vl_i(cmd_vl_i),
    .cmd_ew_i(cmd_ew_i), .cmd_strided_i(cmd_strided_i), .cmd_store_i(cmd_store_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_strb_o(req_strb_o), .req_we_o(req_we_o), .req_id_o(req_id_o),
    .req_elem_o(req_elem_o), .rsp_valid_i(rsp_valid_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] l_addr [P][64];
  logic [31:0] l_strb [P][64];
  logic [31:0] l_id   [P][64];
  logic [31:0] l_elem [P][64];
  logic [31:0] l_we   [P][64];
  int          n_hs [P];
  int          done_cnt, done_cyc, done_os, done_rsp, rsp_total;
  int          c0, c1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command with ready always high; every handshake is answered one cycle later.
  task automatic run_cmd(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] vl,
                         input logic [1:0] ew, input logic strided, input logic store, input int budget);
    int outstanding;
    logic [P-1:0] pend;
    outstanding = 0; pend = '0;
    done_cnt = 0; done_cyc = -1; done_os = -1; done_rsp = -1; rsp_total = 0;
    for (int p = 0; p < P; p++) n_hs[p] = 0;
    cmd_base_i = base; cmd_stride_i = stride; cmd_vl_i = vl; cmd_ew_i = ew;
    cmd_strided_i = strided; cmd_store_i = store; cmd_valid_i = 1'b1;
    req_ready_i = '1; rsp_valid_i = '0;
    #1;
    chk("cmd_ready_idle", cmd_ready_o, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    chk("busy_after_accept", busy_o, 1);
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done_o) begin
        done_cnt++; done_cyc = cyc; done_os = outstanding; done_rsp = rsp_total;
      end
      rsp_valid_i = pend;
      for (int p = 0; p < P; p++) if (pend[p]) begin outstanding--; rsp_total++; end
      pend = '0;
      #1;
      for (int p = 0; p < P; p++) begin
        if (req_valid_o[p] && req_ready_i[p] && n_hs[p] < 64) begin
          l_addr[p][n_hs[p]] = req_addr_o[p*AW +: AW];
          l_strb[p][n_hs[p]] = 32'(req_strb_o[p*EB +: EB]);
          l_id[p][n_hs[p]]   = 32'(req_id_o[p*IW +: IW]);
          l_elem[p][n_hs[p]] = 32'(req_elem_o[p*VW +: VW]);
          l_we[p][n_hs[p]]   = 32'(req_we_o[p]);
          n_hs[p]++;
          pend[p] = 1'b1;
          outstanding++;
        end
      end
      if (done_cnt != 0) break;
      @(posedge clk_i); #1;
    end
    rsp_valid_i = '0;
    @(posedge clk_i); #1;
    chk("done_count", done_cnt, 1);
    chk("done_single_pulse", done_o, 0);
    chk("idle_after_done", busy_o, 0);
    chk("no_outstanding_at_done", done_os, 0);
  endtask

  // Count handshakes over ncyc cycles; rsp_first is driven during the first cycle only.
  task automatic cyc_count(input int ncyc, input logic [P-1:0] rsp_first, output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int i = 0; i < ncyc; i++) begin
      rsp_valid_i = (i == 0) ? rsp_first : '0;
      #1;
      if (req_valid_o[0] && req_ready_i[0]) h0++;
      if (req_valid_o[1] && req_ready_i[1]) h1++;
      @(posedge clk_i); #1;
    end
    rsp_valid_i = '0;
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_base_i = '0; cmd_stride_i = '0; cmd_vl_i = '0;
    cmd_ew_i = '0; cmd_strided_i = 1'b0; cmd_store_i = 1'b0; req_ready_i = '0; rsp_valid_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_req_valid", 32'(req_valid_o), 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_addr", req_addr_o[31:0] | req_addr_o[63:32], 0);
    chk("rst_strb", 32'(req_strb_o), 0);
    chk("rst_id", 32'(req_id_o), 0);
    chk("rst_elem", 32'(req_elem_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // word mode, 32-bit elements, 10 words over two ports
    run_cmd(32'h1000, 32'h0, 16'd10, 2'd2, 1'b0, 1'b0, 60);
    chk("t1_hs_p0", n_hs[0], 5);
    chk("t1_hs_p1", n_hs[1], 5);
    for (int k = 0; k < 5; k++) begin
      chk("t1_addr_p0", l_addr[0][k], 32'h1000 + 32'(8 * k));
      chk("t1_addr_p1", l_addr[1][k], 32'h1004 + 32'(8 * k));
      chk("t1_strb_p0", l_strb[0][k], 32'hF);
      chk("t1_strb_p1", l_strb[1][k], 32'hF);
      chk("t1_id_p0", l_id[0][k], 32'(k));
      chk("t1_id_p1", l_id[1][k], 32'(k));
      chk("t1_elem_p0", l_elem[0][k], 32'(2 * k));
      chk("t1_elem_p1", l_elem[1][k], 32'(2 * k + 1));
      chk("t1_we_p0", l_we[0][k], 0);
    end
    chk("t1_rsp_before_done", done_rsp, 10);

    // word mode with partial tail: 5 bytes -> 2 words, last strobe 0x1
    run_cmd(32'h1000, 32'h0, 16'd5, 2'd0, 1'b0, 1'b0, 40);
    chk("t2_hs_p0", n_hs[0], 1);
    chk("t2_hs_p1", n_hs[1], 1);
    chk("t2_addr_p0", l_addr[0][0], 32'h1000);
    chk("t2_strb_p0", l_strb[0][0], 32'hF);
    chk("t2_elem_p0", l_elem[0][0], 0);
    chk("t2_addr_p1", l_addr[1][0], 32'h1004);
    chk("t2_strb_p1", l_strb[1][0], 32'h1);
    chk("t2_elem_p1", l_elem[1][0], 4);

    // strided store with negative stride, 16-bit elements
    run_cmd(32'h2002, 32'hFFFF_FFFA, 16'd3, 2'd1, 1'b1, 1'b1, 40);
    chk("t3_hs_p0", n_hs[0], 2);
    chk("t3_hs_p1", n_hs[1], 1);
    chk("t3_addr_p0_0", l_addr[0][0], 32'h2000);
    chk("t3_strb_p0_0", l_strb[0][0], 32'hC);
    chk("t3_addr_p1_0", l_addr[1][0], 32'h1FFC);
    chk("t3_strb_p1_0", l_strb[1][0], 32'h3);
    chk("t3_elem_p1_0", l_elem[1][0], 1);
    chk("t3_addr_p0_1", l_addr[0][1], 32'h1FF4);
    chk("t3_strb_p0_1", l_strb[0][1], 32'hC);
    chk("t3_elem_p0_1", l_elem[0][1], 2);
    chk("t3_id_p0_1", l_id[0][1], 1);
    chk("t3_we_p0", l_we[0][0], 1);
    chk("t3_we_p1", l_we[1][0], 1);

    // misaligned unit-stride bytes: element mode, stride register ignored
    run_cmd(32'h1001, 32'h55, 16'd3, 2'd0, 1'b0, 1'b0, 40);
    chk("t4_hs_p0", n_hs[0], 2);
    chk("t4_hs_p1", n_hs[1], 1);
    chk("t4_addr_p0_0", l_addr[0][0], 32'h1000);
    chk("t4_strb_p0_0", l_strb[0][0], 32'h2);
    chk("t4_addr_p1_0", l_addr[1][0], 32'h1000);
    chk("t4_strb_p1_0", l_strb[1][0], 32'h4);
    chk("t4_addr_p0_1", l_addr[0][1], 32'h1000);
    chk("t4_strb_p0_1", l_strb[0][1], 32'h8);
    chk("t4_elem_p0_1", l_elem[0][1], 2);

    // vl = 0: no requests, done the cycle after accept
    run_cmd(32'h4000, 32'h0, 16'd0, 2'd2, 1'b0, 1'b0, 20);
    chk("t5_hs_p0", n_hs[0], 0);
    chk("t5_hs_p1", n_hs[1], 0);
    chk("t5_done_cycle", done_cyc, 0);

    // credit limit: 40 words, no responses
    cmd_base_i = 32'h0; cmd_stride_i = '0; cmd_vl_i = 16'd40; cmd_ew_i = 2'd2;
    cmd_strided_i = 1'b0; cmd_store_i = 1'b0; req_ready_i = '1; rsp_valid_i = '0;
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    cyc_count(20, 2'b00, c0, c1);
    chk("cr_hs_p0", c0, 8);
    chk("cr_hs_p1", c1, 8);
    chk("cr_valid_low", 32'(req_valid_o), 0);
    chk("cr_id_wrap_p0", 32'(req_id_o[IW-1:0]), 0);
    chk("cr_addr_p0", req_addr_o[31:0], 32'h40);
    chk("cr_addr_p1", req_addr_o[63:32], 32'h44);
    cyc_count(5, 2'b01, c0, c1);
    chk("cr_one_more_p0", c0, 1);
    chk("cr_none_p1", c1, 0);
    cyc_count(1, 2'b10, c0, c1);
    chk("cr_rsp_only_p1", c1, 0);
    cyc_count(1, 2'b10, c0, c1);
    chk("cr_hs_with_rsp_p1", c1, 1);
    cyc_count(4, 2'b00, c0, c1);
    chk("cr_after_simul_p1", c1, 1);
    chk("cr_after_simul_p0", c0, 0);
    chk("cr_still_busy", busy_o, 1);

    // synchronous reset mid-ISSUE, then stray responses
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("mr_valid_low", 32'(req_valid_o), 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_done", done_o, 0);
    chk("mr_ready", cmd_ready_o, 1);
    rst_i = 1'b0;
    rsp_valid_i = '1;
    @(posedge clk_i); #1;
    rsp_valid_i = '0;
    chk("mr_stray_done", done_o, 0);
    chk("mr_stray_busy", busy_o, 0);

    // a fresh command must run normally, proving credits and IDs restarted at 0
    run_cmd(32'h3000, 32'h0, 16'd4, 2'd2, 1'b0, 1'b0, 40);
    chk("t7_hs_p0", n_hs[0], 2);
    chk("t7_hs_p1", n_hs[1], 2);
    chk("t7_addr_p0_1", l_addr[0][1], 32'h3008);
    chk("t7_addr_p1_0", l_addr[1][0], 32'h3004);
    chk("t7_id_p0_0", l_id[0][0], 0);
    chk("t7_id_p1_1", l_id[1][1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spatz_vlsu_mem_sequencer.md
Name: spatz_vlsu_mem_sequencer

Overview:
Multi-port memory request sequencer for the Spatz VLSU. Takes one vector memory command (unit-stride or strided, load or store) and spreads its word or element requests across NrMemPorts ports. Each port has its own address generator, transaction-ID counter and outstanding-request credit counter. The block finishes a command only after every issued request has been acknowledged. It sits between the VLSU command decode and the X-interface memory ports; data and the reorder buffer stay outside this block.

Parameters:
NrMemPorts, 2, number of independent memory ports (>=1, power of two)
NrOutstanding, 8, max in-flight requests per port (power of two); IdWidth = clog2(NrOutstanding)
AddrWidth, 32, address width
VlWidth, 16, width of vector length and element-index fields
ElenB, 4, bytes per port data word (power of two)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_base_i  in  AddrWidth  base address (rs1)
cmd_stride_i  in  AddrWidth  signed byte stride (rs2), used when strided
cmd_vl_i  in  VlWidth  element count
cmd_ew_i  in  2  element width: 0=8b, 1=16b, 2=32b (3 is illegal and is treated as 2)
cmd_strided_i  in  1  1=strided, 0=unit-stride
cmd_store_i  in  1  1=store, 0=load
req_valid_o  out  NrMemPorts  per-port request valid
req_ready_i  in  NrMemPorts  per-port request ready
req_addr_o  out  NrMemPorts*AddrWidth  word-aligned request address
req_strb_o  out  NrMemPorts*ElenB  byte enables
req_we_o  out  NrMemPorts  write enable (= latched cmd_store)
req_id_o  out  NrMemPorts*IdWidth  transaction ID
req_elem_o  out  NrMemPorts*VlWidth  index of first element carried
rsp_valid_i  in  NrMemPorts  per-port load result or store ack
busy_o  out  1  command in progress
done_o  out  1  one-cycle pulse when a command completes

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all counters 0; state IDLE; cmd_ready_o=1; req_valid_o=0; busy_o=0; done_o=0; addr/strb/id/elem outputs 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: cmd_ready_o=1. On cmd handshake, latch the command and go to ISSUE.
  - Exception: if vl=0, go directly to DRAIN; done_o pulses the next cycle and no requests are issued.
  - ISSUE: cmd_ready_o=0. Go to DRAIN when every port has issued its full quota.
  - DRAIN: stay until all credit counters are 0. Then pulse done_o for one cycle (the cycle state returns to IDLE) and return to IDLE. The next command may be accepted in the cycle after done_o.
- busy_o = (state != IDLE).
- Mode selection:
  - eb = 1<<ew.
  - Word mode: unit-stride and base[clog2(ElenB)-1:0]==0.
  - Element mode: strided, or unit-stride with a misaligned base. Misaligned unit-stride uses element mode with stride=eb.
- Request counts:
  - Word mode: W = ceil(vl*eb/ElenB) requests.
  - Element mode: W = vl requests.
  - Global request r goes to port r mod P (P = NrMemPorts).
  - Port i quota = floor(W/P) + (i < W mod P).
- Addresses (computed mod 2^AddrWidth):
  - Step = ElenB in word mode, stride in element mode.
  - Each port's running address is initialised to base + i*step on command accept.
  - On each req handshake, the running address advances by P*step.
  - req_addr_o = running address with the low clog2(ElenB) bits cleared.
- Byte strobes:
  - Word mode: all ones, except on the final global request, where only the low ((vl*eb) mod ElenB) bytes are set (all ones if that value is 0).
  - Element mode: ((1<<eb)-1) << addr_lo, where addr_lo is the low clog2(ElenB) bits of the running address. Elements are naturally aligned; a word-crossing element is illegal and truncated to in-word bytes.
- req_elem_o:
  - Word mode: r*ElenB/eb.
  - Element mode: r.
- Credits and request gating:
  - req_valid_o[i] = ISSUE & quota remaining & credit[i] < NrOutstanding.
  - Request signals are stable while valid && !ready.
  - credit[i] increments on a req handshake and decrements on rsp_valid_i[i]. If both happen in the same cycle, credit is unchanged.
  - A decrement at 0 saturates at 0: stray response after reset, no underflow.
- IDs: req_id_o[i] starts at 0 per command, increments on each handshake and wraps modulo NrOutstanding.
- Reset mid-operation: everything returns to reset values next cycle, no done_o; late rsp_valid_i is ignored.

Test Plan:
- P=2, word mode, load, base 0x1000, ew32, vl=10 → port0 issues 0x1000,0x1008..0x1020; port1 issues 0x1004..0x1024; strb 0xF; IDs 0..4 per port; done_o pulses only after 10 rsp.
- Word-mode partial tail: base 0x1000, ew8, vl=5 → W=2; port0 0x1000 strb 0xF elem 0; port1 0x1004 strb 0x1 elem 4.
- Strided store: base 0x2002, stride −6, ew16, vl=3 → port0 0x2000 strb 0xC; port1 0x1FFC strb 0x3; port0 0x1FF4 strb 0xC; req_we_o=1.
- Misaligned unit-stride: base 0x1001, ew8, vl=3 → element mode; addrs 0x1000/0x1000/0x1000, strb 0x2,0x4,0x8 on ports 0,1,0.
- Credit limit: NrOutstanding=8, vl=40 ew32, req_ready_i=1, no rsp → exactly 8 handshakes per port, then valid low. One rsp on port0 → exactly one more port0 request. Simultaneous handshake+rsp → credit unchanged.
- vl=0 → no req_valid_o, done_o one cycle after accept. Reset asserted mid-ISSUE → valid low next cycle, no done_o, a following rsp_valid_i leaves credits at 0.
